dir_rom_arbiter: RTL and testbench

- Round-robin arbiter and sequencer sharing one combinational direction-lookup ROM (8-bit address, 5-bit two's-complement offset) between NUM_REQ requesters, e.g. parallel orientation/descriptor lanes.
- Accepts address requests via valid/ready, drives the ROM address from a register, and captures the ROM data.
- Returns the result to the originating requester with fixed 2-cycle latency, at one lookup per cycle.

---
 rtl/dir_rom_arbiter.sv | 104 ++++++++++
 tb/tb_dir_rom_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dir_rom_arbiter.sv
// Shares one combinational direction ROM among NUM_REQ requesters with a fixed two-cycle lookup pipeline.
// Define DIR_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module dir_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         rom_a,
    input  logic [DATA_W-1:0]         rom_spo,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0] rsp_data,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] grant_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic               xfer_s;
    logic               s1_v_r;
    logic [IDX_W-1:0]   s1_id_r;
    int                 idx_s;
`ifndef DIR_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]   ptr_r;
`endif

    // Grant search: first valid lane from the search start, wrapping around.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = '0;
        xfer_s      = 1'b0;
        idx_s       = 0;
        if (en && !rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
`ifdef DIR_ARB_FIXED_PRIO_EN
                idx_s = k;
`else
                idx_s = int'(ptr_r) + k;
                if (idx_s >= NUM_REQ) begin
                    idx_s = idx_s - NUM_REQ;
                end else begin
                    idx_s = idx_s;
                end
`endif
                if (!xfer_s && req_valid[idx_s]) begin
                    xfer_s         = 1'b1;
                    grant_s[idx_s] = 1'b1;
                    grant_idx_s    = IDX_W'(idx_s);
                end else begin
                    xfer_s = xfer_s;
                end
            end
        end else begin
            xfer_s = 1'b0;
        end
    end

    assign req_ready = grant_s;

    // Stage 1 latches the granted address; stage 2 routes ROM data back to its lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_a     <= '0;
            s1_v_r    <= 1'b0;
            s1_id_r   <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
`ifndef DIR_ARB_FIXED_PRIO_EN
            ptr_r     <= '0;
`endif
        end else begin
            s1_v_r <= xfer_s;
            busy   <= xfer_s | s1_v_r;
            if (xfer_s) begin
                rom_a   <= req_addr[int'(grant_idx_s)*ADDR_W +: ADDR_W];
                s1_id_r <= grant_idx_s;
`ifndef DIR_ARB_FIXED_PRIO_EN
                if (int'(grant_idx_s) == NUM_REQ - 1) begin
                    ptr_r <= '0;
                end else begin
                    ptr_r <= grant_idx_s + IDX_W'(1);
                end
`endif
            end else begin
                rom_a <= rom_a;
            end
            rsp_valid <= '0;
            if (s1_v_r) begin
                rsp_valid[s1_id_r]                         <= 1'b1;
                rsp_data[int'(s1_id_r)*DATA_W +: DATA_W]   <= rom_spo;
            end else begin
                rsp_data <= rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_dir_rom_arbiter.sv
// Self-checking bench for dir_rom_arbiter: directed scenarios plus random traffic against a
// transaction-level model (search order, pending-lookup list, ROM = addr[7:3]).
module tb_dir_rom_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 5;

    logic          clk = 1'b0;
    logic          rst, en;
    logic [N-1:0]  req_valid, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [AW-1:0] rom_a;
    logic [DW-1:0] rom_spo;
    logic [N*DW-1:0] rsp_data;
    logic          busy;

    always #5 clk = ~clk;
    assign rom_spo = rom_a[7:3];

    dir_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .rom_a(rom_a), .rom_spo(rom_spo), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .busy(busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int m_ptr  = 0;
    logic [AW-1:0] m_rom_a = '0;
    logic [DW-1:0] m_data [N];
    int pl[$];
    int pd[$];
    int pc[$];
    logic [N-1:0]    obs_ready, obs_valid;
    logic [N*DW-1:0] obs_data;

    function automatic int rom(input logic [AW-1:0] a);
        return int'(a) / 8;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [N-1:0] v, input logic [N*AW-1:0] a);
        int g;
        logic [N-1:0] er, ev;
        logic [N*DW-1:0] ed;
        logic be;
        rst = r; en = e; req_valid = v; req_addr = a;
        #2;
        g = -1;
        if (!r && e) begin
            for (int k = 0; k < N; k++) begin
                int idx;
`ifdef DIR_ARB_FIXED_PRIO_EN
                idx = k;
`else
                idx = (m_ptr + k) % N;
`endif
                if (g < 0 && v[idx]) g = idx;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        ev = '0;
        be = 1'b0;
        for (int i = 0; i < pl.size(); i++) begin
            if (pc[i] + 2 == cyc) begin
                ev[pl[i]] = 1'b1;
                m_data[pl[i]] = DW'(pd[i]);
            end
            if (pc[i] < cyc && pc[i] + 2 >= cyc) be = 1'b1;
        end
        for (int i = 0; i < N; i++) ed[i*DW +: DW] = m_data[i];
        obs_ready = req_ready; obs_valid = rsp_valid; obs_data = rsp_data;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rom_a", 32'(rom_a), 32'(m_rom_a));
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        chk("rsp_data", 32'(rsp_data), 32'(ed));
        chk("busy", 32'(busy), 32'(be));
        while (pl.size() > 0 && pc[0] + 2 <= cyc) begin
            void'(pl.pop_front()); void'(pd.pop_front()); void'(pc.pop_front());
        end
        @(posedge clk);
        if (r) begin
            pl.delete(); pd.delete(); pc.delete();
            m_ptr = 0; m_rom_a = '0;
            for (int i = 0; i < N; i++) m_data[i] = '0;
        end else if (g >= 0) begin
            pl.push_back(g);
            pd.push_back(rom(a[g*AW +: AW]));
            pc.push_back(cyc);
            m_rom_a = a[g*AW +: AW];
            m_ptr = (g + 1) % N;
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 4'b0000, '0);
    endtask

    initial begin
        logic [N*AW-1:0] ra;
        for (int i = 0; i < N; i++) m_data[i] = '0;
        rst = 1'b1; en = 1'b0; req_valid = '0; req_addr = '0;
        @(posedge clk); #1;

        // Single lookup latency and ROM pass-through
        step(1'b1, 1'b0, 4'b0000, '0);
        step(1'b0, 1'b1, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h58});
        chk("t1_ready", 32'(obs_ready), 32'h1);
        step(1'b0, 1'b1, 4'b0000, '0);
        step(1'b0, 1'b1, 4'b0000, '0);
        chk("t1_valid", 32'(obs_valid), 32'h1);
        chk("t1_data", 32'(obs_data[4:0]), 32'h0B);
        idle(2);

        // All lanes held for 8 cycles from reset
        step(1'b1, 1'b0, 4'b0000, '0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 4'b1111, {8'hF8, 8'h10, 8'h08, 8'h00});
`ifdef DIR_ARB_FIXED_PRIO_EN
            chk("t2_grant", 32'(obs_ready), 32'h1);
`else
            chk("t2_grant", 32'(obs_ready), 32'(1 << (i % 4)));
`endif
        end
        idle(3);

        // Lanes 1 and 3 with pointer at 2
        step(1'b1, 1'b0, 4'b0000, '0);
        step(1'b0, 1'b1, 4'b0010, {8'h30, 8'h20, 8'h10, 8'h00});
        step(1'b0, 1'b1, 4'b1010, {8'h30, 8'h20, 8'h10, 8'h00});
`ifdef DIR_ARB_FIXED_PRIO_EN
        chk("t3_first", 32'(obs_ready), 32'h2);
`else
        chk("t3_first", 32'(obs_ready), 32'h8);
`endif
        step(1'b0, 1'b1, 4'b1010, {8'h30, 8'h20, 8'h10, 8'h00});
        chk("t3_second", 32'(obs_ready), 32'h2);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 4'b0010, {8'h30, 8'h28, 8'h10, 8'h00});
            chk("t3_single", 32'(obs_ready), 32'h2);
        end
        idle(2);

        // Enable low while lanes 0 and 2 request
        step(1'b1, 1'b0, 4'b0000, '0);
        step(1'b0, 1'b1, 4'b0101, {8'h00, 8'h48, 8'h00, 8'hA0});
        step(1'b0, 1'b1, 4'b0101, {8'h00, 8'h48, 8'h00, 8'hA0});
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 4'b0101, {8'h00, 8'h48, 8'h00, 8'hA0});
            chk("t4_en_off", 32'(obs_ready), 32'h0);
        end
        step(1'b0, 1'b1, 4'b0101, {8'h00, 8'h48, 8'h00, 8'hA0});
        step(1'b0, 1'b1, 4'b0101, {8'h00, 8'h48, 8'h00, 8'hA0});
        idle(3);

        // Reset right after a grant discards the lookup
        step(1'b0, 1'b1, 4'b0100, {8'h00, 8'hE0, 8'h00, 8'h00});
        step(1'b1, 1'b1, 4'b0100, {8'h00, 8'hE0, 8'h00, 8'h00});
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 4'b0000, '0);
            chk("t5_no_rsp", 32'(obs_valid), 32'h0);
        end

`ifdef DIR_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 4'b0101, {8'h00, 8'h18, 8'h00, 8'h08});
            chk("fp_lane0", 32'(obs_ready), 32'h1);
        end
        idle(2);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            ra = {$urandom, $urandom};
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) != 0), N'($urandom), ra);
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
